// File: rtl/sparc_ctrl_pkg.sv
// Shared encodings for the SPARC control unit: FSM states, forced ALU
// opcode, mux selects, memory access size and timeout limit.
package sparc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH1    = 4'd1,
    S_FETCH2    = 4'd2,
    S_FETCH3    = 4'd3,
    S_DECODE    = 4'd4,
    S_EXEC_ALU  = 4'd5,
    S_EXEC_BR   = 4'd6,
    S_EXEC_MEM1 = 4'd7,
    S_EXEC_MEM2 = 4'd8,
    S_ERROR     = 4'd9
  } state_e;

  // Forced ALU opcode used to advance the PC during fetch
  localparam logic [5:0] OPXX_PC_INC = 6'b010001;

  // Memory access size
  localparam logic [1:0] TYPE_WORD = 2'b10;

  // ALU-B source selects
  localparam logic [1:0] MB_IR_IMM = 2'b01;
  localparam logic [1:0] MB_CONST  = 2'b10;

  // PC / nPC source selects
  localparam logic [1:0] MP_ZERO = 2'b00;
  localparam logic [1:0] MP_ALU  = 2'b11;
  localparam logic [1:0] MNP_SEQ = 2'b11;

  // Instruction class, IR[31:30]
  localparam logic [1:0] IR_CLS_CALL = 2'b01;
  localparam logic [1:0] IR_CLS_ALU  = 2'b10;
  localparam logic [1:0] IR_CLS_MEM  = 2'b11;

  // Last wait-counter value before a memory access is declared timed out
  localparam logic [3:0] WAIT_MAX = 4'hF;

  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH2) || (s == S_EXEC_MEM2);
  endfunction

endpackage

// File: rtl/sparc_moc_timer.sv
// Memory wait counter: counts cycles without MOC while the FSM waits on
// memory and flags a timeout once the count is exhausted.
module sparc_moc_timer
  import sparc_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic moc_i,
  output logic timeout_o
);

  logic [3:0] cnt_q, cnt_d;

  // Counter register, cleared asynchronously by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Held at zero outside the wait states, so every wait starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (!wait_i)     cnt_d = '0;
    else if (!moc_i) cnt_d = cnt_q + 4'd1;
  end

  // MOC arriving on the last count wins over the timeout
  assign timeout_o = wait_i && !moc_i && (cnt_q == WAIT_MAX);

endmodule

// File: rtl/sparc_control_unit.sv
// SPARC multicycle control unit: fetch / decode / execute FSM with
// combinational output decode and a memory-handshake timeout.
module sparc_control_unit
  import sparc_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        BCOND,
  output logic        RF_Clear_Enable,
  output logic        RF_Load_Enable,
  output logic        IR_Ld,
  output logic        MAR_Ld,
  output logic        MDR_Ld,
  output logic        PC_Ld,
  output logic        NPC_Ld,
  output logic        RW,
  output logic        MOV,
  output logic [1:0]  Type,
  output logic [1:0]  MB,
  output logic [1:0]  MP,
  output logic [1:0]  MNP,
  output logic        MOP,
  output logic        MR,
  output logic [5:0]  OpXX,
  output logic        Mem_Err,
  output logic [3:0]  State
);

  state_e state_q, state_d;
  logic   rst_dly_q;
  logic   mem_err_q, mem_err_d;
  logic   moc_timeout;
  logic   unused_ir;

  assign unused_ir = ^{IR[29:22], IR[20:0]};

  sparc_moc_timer u_timer (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .wait_i    (is_wait_state(state_q)),
    .moc_i     (MOC),
    .timeout_o (moc_timeout)
  );

  // State, reset-release delay and sticky error registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_RESET;
      rst_dly_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_dly_q <= 1'b1;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    mem_err_d       = mem_err_q | moc_timeout;
    RF_Clear_Enable = 1'b0;
    RF_Load_Enable  = 1'b0;
    IR_Ld           = 1'b0;
    MAR_Ld          = 1'b0;
    MDR_Ld          = 1'b0;
    PC_Ld           = 1'b0;
    NPC_Ld          = 1'b0;
    RW              = 1'b0;
    MOV             = 1'b0;
    Type            = '0;
    MB              = '0;
    MP              = '0;
    MNP             = '0;
    MOP             = 1'b0;
    MR              = 1'b0;
    OpXX            = '0;

    unique case (state_q)
      S_RESET: begin
        RF_Clear_Enable = 1'b1;
        PC_Ld           = 1'b1;
        NPC_Ld          = 1'b1;
        MR              = 1'b1;
        MNP             = MNP_SEQ;
        MP              = MP_ZERO;
        // One extra RESET cycle after release so FETCH1 lands on the second edge
        if (rst_dly_q) state_d = S_FETCH1;
      end
      S_FETCH1: begin
        MAR_Ld  = 1'b1;
        OpXX    = OPXX_PC_INC;
        MB      = MB_CONST;
        MP      = MP_ALU;
        MOP     = 1'b1;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        RW    = 1'b1;
        MOV   = 1'b1;
        Type  = TYPE_WORD;
        MP    = MP_ALU;
        MNP   = MNP_SEQ;
        PC_Ld = MOC;
        if (MOC)              state_d = S_FETCH3;
        else if (moc_timeout) state_d = S_ERROR;
      end
      S_FETCH3: begin
        IR_Ld   = 1'b1;
        NPC_Ld  = 1'b1;
        RW      = 1'b1;
        MOV     = 1'b1;
        Type    = TYPE_WORD;
        MNP     = MNP_SEQ;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (IR[31:30])
          IR_CLS_ALU: state_d = S_EXEC_ALU;
          IR_CLS_MEM: state_d = S_EXEC_MEM1;
          default:    state_d = S_EXEC_BR;
        endcase
      end
      S_EXEC_ALU: begin
        RF_Load_Enable = 1'b1;
        state_d        = S_FETCH1;
      end
      S_EXEC_BR: begin
        if (BCOND || (IR[31:30] == IR_CLS_CALL)) begin
          PC_Ld  = 1'b1;
          NPC_Ld = 1'b1;
        end
        state_d = S_FETCH1;
      end
      S_EXEC_MEM1: begin
        MAR_Ld  = 1'b1;
        MB      = MB_IR_IMM;
        state_d = S_EXEC_MEM2;
      end
      S_EXEC_MEM2: begin
        RW   = ~IR[21];
        MOV  = 1'b1;
        Type = TYPE_WORD;
        if (MOC) begin
          if (!IR[21]) begin
            RF_Load_Enable = 1'b1;
            MDR_Ld         = 1'b1;
          end
          state_d = S_FETCH1;
        end else if (moc_timeout) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign Mem_Err = mem_err_q;
  assign State   = state_q;

endmodule

// File: tb/tb_sparc_control_unit.sv
// Self-checking bench for sparc_control_unit: instruction-level planner
// decides how many cycles each phase lasts, and every cycle the full
// output vector is compared against the state's output table.
module tb_sparc_control_unit;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [31:0] IR = '0;
  logic        MOC = 1'b0;
  logic        BCOND = 1'b0;
  logic        RF_Clear_Enable, RF_Load_Enable, IR_Ld, MAR_Ld, MDR_Ld;
  logic        PC_Ld, NPC_Ld, RW, MOV, MOP, MR, Mem_Err;
  logic [1:0]  Type, MB, MP, MNP;
  logic [5:0]  OpXX;
  logic [3:0]  State;

  always #5 Clk = ~Clk;

  sparc_control_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .IR(IR), .MOC(MOC), .BCOND(BCOND),
    .RF_Clear_Enable(RF_Clear_Enable), .RF_Load_Enable(RF_Load_Enable),
    .IR_Ld(IR_Ld), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld), .PC_Ld(PC_Ld),
    .NPC_Ld(NPC_Ld), .RW(RW), .MOV(MOV), .Type(Type), .MB(MB), .MP(MP),
    .MNP(MNP), .MOP(MOP), .MR(MR), .OpXX(OpXX), .Mem_Err(Mem_Err),
    .State(State)
  );

  // Debug state codes, in the order the states are listed
  localparam logic [3:0] ST_RESET = 4'd0, ST_F1 = 4'd1, ST_F2 = 4'd2,
                         ST_F3 = 4'd3, ST_DEC = 4'd4, ST_ALU = 4'd5,
                         ST_BR = 4'd6, ST_M1 = 4'd7, ST_M2 = 4'd8,
                         ST_ERR = 4'd9;

  // A memory wait may see MOC=0 on 16 cycles (counter 0..15); the 16th
  // such cycle times out, MOC on that cycle still succeeds.
  localparam int WAIT_LIMIT = 16;

  typedef struct packed {
    logic rfc, rfl, irl, marl, mdrl, pcl, npcl, rw, mov;
    logic [1:0] ty, mb, mp, mnp;
    logic mop, mr;
    logic [5:0] opxx;
    logic merr;
    logic [3:0] st;
  } ov_t;

  ov_t  obs;
  assign obs = {RF_Clear_Enable, RF_Load_Enable, IR_Ld, MAR_Ld, MDR_Ld,
                PC_Ld, NPC_Ld, RW, MOV, Type, MB, MP, MNP, MOP, MR, OpXX,
                Mem_Err, State};

  int   total = 0;
  int   bad = 0;
  logic memerr_exp = 1'b0;
  int   irld_cnt = 0;
  int   rfl_cnt = 0;

  // Output table of each state
  function automatic ov_t model(input logic [3:0] st, input logic [31:0] ir,
                                input logic moc, input logic bc,
                                input logic merr);
    ov_t e;
    e = '0;
    e.st = st;
    e.merr = merr;
    case (st)
      ST_RESET: begin e.rfc = 1; e.pcl = 1; e.npcl = 1; e.mr = 1; e.mnp = 2'b11; end
      ST_F1: begin e.marl = 1; e.opxx = 6'b010001; e.mb = 2'b10; e.mp = 2'b11; e.mop = 1; end
      ST_F2: begin e.rw = 1; e.mov = 1; e.ty = 2'b10; e.mp = 2'b11; e.mnp = 2'b11; e.pcl = moc; end
      ST_F3: begin e.irl = 1; e.npcl = 1; e.rw = 1; e.mov = 1; e.ty = 2'b10; e.mnp = 2'b11; end
      ST_ALU: e.rfl = 1;
      ST_BR: begin e.pcl = bc | (ir[31:30] == 2'b01); e.npcl = e.pcl; end
      ST_M1: begin e.marl = 1; e.mb = 2'b01; end
      ST_M2: begin
        e.rw = ~ir[21]; e.mov = 1; e.ty = 2'b10;
        e.rfl = moc & ~ir[21]; e.mdrl = moc & ~ir[21];
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input logic [3:0] st, input string tag);
    ov_t e;
    e = model(st, IR, MOC, BCOND, memerr_exp);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (state got %0d want %0d)",
             tag, obs, e, State, st);
    end
    irld_cnt += int'(IR_Ld);
    rfl_cnt  += int'(RF_Load_Enable);
  endtask

  task automatic step(input logic [3:0] st, input logic m, input string tag);
    @(negedge Clk);
    MOC = m;
    #1;
    chk(st, tag);
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Wait phase: w MOC=0 cycles then MOC=1, or a timeout when w >= limit
  task automatic mem_wait(input logic [3:0] st, input int w, output logic to);
    to = (w >= WAIT_LIMIT);
    for (int i = 0; i < (to ? WAIT_LIMIT : w); i++) step(st, 1'b0, "wait");
    if (to) begin
      memerr_exp = 1'b1;
      for (int i = 0; i < 3; i++) step(ST_ERR, rbit(), "error_hold");
    end else begin
      step(st, 1'b1, "wait_done");
    end
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic bc,
                           input int fw, input int mw);
    logic to;
    @(negedge Clk);
    IR = ir; BCOND = bc; MOC = rbit();
    #1;
    chk(ST_F1, "fetch1");
    mem_wait(ST_F2, fw, to);
    if (!to) begin
      step(ST_F3, rbit(), "fetch3");
      step(ST_DEC, rbit(), "decode");
      case (ir[31:30])
        2'b10: step(ST_ALU, rbit(), "exec_alu");
        2'b11: begin
          step(ST_M1, rbit(), "exec_mem1");
          mem_wait(ST_M2, mw, to);
        end
        default: step(ST_BR, rbit(), "exec_br");
      endcase
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    #3;
    Reset_n = 1'b0;
    memerr_exp = 1'b0;
    #1;
    chk(ST_RESET, tag);
    @(negedge Clk);
    Reset_n = 1'b1;
    MOC = rbit();
    #1;
    chk(ST_RESET, "reset_release0");
    step(ST_RESET, rbit(), "reset_release1");
  endtask

  task automatic count_check(input int got, input int want, input string tag);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  initial begin
    logic [31:0] r;
    #1 Reset_n = 1'b0;
    #1 chk(ST_RESET, "reset_async");
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 chk(ST_RESET, "reset_release0");
    step(ST_RESET, 1'b1, "reset_release1");

    irld_cnt = 0;
    run_instr(32'h8200_4003, 1'b0, 0, 0);
    count_check(irld_cnt, 1, "ir_ld_pulses");

    rfl_cnt = 0;
    run_instr(32'h8200_4003, 1'b0, 3, 0);
    count_check(rfl_cnt, 1, "alu_rf_load_pulses");

    run_instr(32'h1080_0004, 1'b0, 1, 0);
    run_instr(32'h1080_0004, 1'b1, 2, 0);
    run_instr(32'h4000_0010, 1'b0, 0, 0);

    rfl_cnt = 0;
    run_instr(32'hC200_4000, 1'b0, 0, 2);
    count_check(rfl_cnt, 1, "load_rf_load_pulses");
    rfl_cnt = 0;
    run_instr(32'hC220_4000, 1'b0, 1, 1);
    count_check(rfl_cnt, 0, "store_rf_load_pulses");

    run_instr(32'h8200_4003, 1'b0, WAIT_LIMIT - 1, 0);
    run_instr(32'hC200_4000, 1'b1, 0, WAIT_LIMIT - 1);

    for (int n = 0; n < 30; n++) begin
      r = $urandom;
      run_instr(r, rbit(), $urandom_range(0, 6), $urandom_range(0, 6));
    end

    run_instr(32'h8200_4003, 1'b0, WAIT_LIMIT, 0);
    do_reset("reset_clears_err");

    run_instr(32'hC220_4000, 1'b0, 0, WAIT_LIMIT);
    do_reset("reset_after_mem_err");

    step(ST_F1, 1'b0, "fetch1");
    for (int i = 0; i < 7; i++) step(ST_F2, 1'b0, "wait");
    do_reset("reset_mid_fetch");

    run_instr(32'hC200_4000, 1'b0, 0, 4);
    run_instr(32'hC200_4000, 1'b0, 0, WAIT_LIMIT - 1);
    run_instr(32'h8200_4003, 1'b0, WAIT_LIMIT - 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
